ifu_way1: RTL
=============

# ifu_way1

Instruction fetch unit for issue way 1, directly downstream of the way-1 program counter unit. Accepts fetch addresses over a valid/ready handshake, issues them to instruction memory over a req/gnt/rvalid bus, and pairs in-order responses with their PCs. Buffers returned instructions for decode with a valid/ready handshake. On a jump flush, discards every in-flight and buffered fetch.

## Interface
- DEPTH, 2, maximum fetches in flight plus buffered; power of two, ≥2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- pc_valid_i  input  1  fetch address valid from PC unit
- pc_i  input  32  fetch address
- pc_ready_o  output  1  fetch address accepted this cycle; drives PC unit ready
- flush_i  input  1  jump taken; kill all older fetches
- imem_req_o  output  1  memory request
- imem_addr_o  output  32  request address
- imem_gnt_i  input  1  request accepted by memory
- imem_rvalid_i  input  1  response data valid, in request order
- imem_rdata_i  input  32  response instruction
- inst_valid_o  output  1  instruction available to decode
- inst_o  output  32  instruction word
- inst_pc_o  output  32  PC of inst_o
- inst_ready_i  input  1  decode consumes instruction

## Operation
- Reset values: imem_req_o=0, imem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, all counters 0. pc_ready_o=1 after reset (derived).
- Credits: used = outstanding + pending request + buffered entries. pc_ready_o = ~req_q & (used < DEPTH) & ~flush_i.
- Accept (pc_valid_i & pc_ready_o):
  - Next cycle: imem_req_o=1 and imem_addr_o=pc_i.
  - imem_req_o and imem_addr_o stay stable until imem_gnt_i.
- Grant (imem_req_o & imem_gnt_i):
  - Request address is pushed into the in-flight PC queue.
  - outstanding is incremented.
  - imem_req_o drops next cycle unless a new PC was accepted.
- Response (imem_rvalid_i):
  - Pop the in-flight PC queue and decrement outstanding.
  - If the discard count is zero, push {rdata, pc} into the instruction buffer.
  - Otherwise, drop the response and decrement the discard count.
- Output: inst_valid_o = buffer not empty. inst_o and inst_pc_o come from the buffer head and pop on inst_valid_o & inst_ready_i.
- Flush (flush_i):
  - Clear the instruction buffer.
  - discard ← outstanding (after this cycle's grant/response updates).
  - A pending, not-yet-granted request keeps imem_req_o high until granted and is counted into discard when granted.
  - An rvalid in the flush cycle is dropped.
  - No PC is accepted in the flush cycle.
- The fetch state machine has two states:
  - IDLE (req_q=0): goes to REQ on accept.
  - REQ (req_q=1): goes to IDLE on grant with no new accept.
  - req_q=1 forces pc_ready_o=0, so REQ-to-REQ never occurs. Peak throughput is one fetch per two cycles.
- Full buffer: credits guarantee a response always has a free slot. No rvalid back-pressure exists. A rvalid with outstanding=0 is a protocol error (flagged by assertion).

## Timing
- PC accepted at cycle N → imem_req_o=1 at N+1. Grant at N+1 with rvalid at N+2 → inst_valid_o=1 at N+3. Minimum latency is 3 cycles.
- pc_ready_o is combinational from internal state and flush_i only. There is no path from imem_gnt_i or inst_ready_i to pc_ready_o.
- Flush at cycle F → inst_valid_o=0 at F+1. The first post-flush PC can be accepted at F+1 if credits allow.
- Reset asserted mid-fetch clears all state immediately. A response arriving after reset deasserts counts as a protocol error; the bench must not produce one.

## Structure
- A shared core package holds:
  - XLEN=32
  - NOP instruction constant 32'h00000013
  - fetch-entry struct {inst[31:0], pc[31:0]}
- One sub-module, ifu_fifo:
  - parameterised depth/width synchronous FIFO
  - synchronous clear input
  - outputs: full, empty, count
- ifu_fifo is instantiated twice: the in-flight PC queue (width 32) and the instruction buffer (width 64).
- Counters are $clog2(DEPTH+1) bits wide.

## Test plan
- Single fetch: pc 0x4 at cycle 1, gnt at 2, rvalid rdata 0x00A00093 at 3 → at cycle 4, inst_valid_o=1, inst_o=0x00A00093, inst_pc_o=0x4.
- Back-pressure: inst_ready_i=0, issue PCs 0x4 and 0xC with responses → after 2 credits used, pc_ready_o=0; releasing ready yields 0x4 then 0xC in order.
- Flush with 2 in flight: flush_i after grants of 0x4 and 0xC, then both rvalids → neither appears; the next PC 0x100 returns with inst_pc_o=0x100.
- Flush while request ungranted: req held 3 cycles, flush in cycle 2, gnt in cycle 3 then rvalid → response dropped; imem_addr_o unchanged until gnt.
- Flush coincident with rvalid and pc_valid_i: the response is dropped, pc_ready_o=0, and inst_valid_o=0 next cycle.
- Reset mid-operation with 2 buffered entries → all outputs return to their reset values in the same cycle and pc_ready_o=1 after reset deasserts.

Source files
------------

// File: rtl/ifu_way1_pkg.sv
// ============================================================================
// Module  : ifu_way1_pkg
// Brief   : Shared core types and constants for the way-1 fetch unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ifu_way1_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ============================================================================
// Module  : ifu_fifo
// Brief   : Parameterised synchronous FIFO with synchronous clear and count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifu_way1.sv
// ============================================================================
// Module  : ifu_way1
// Brief   : Way-1 instruction fetch: credit-limited req/gnt/rvalid issue with
//           in-order PC pairing, decode buffer and jump-flush discard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ifu_way1
  import ifu_way1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_valid_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_ready_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e    state_q;
  logic [XLEN-1:0] addr_q;
  logic            kill_pend_q;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic            req_q, accept, grant, resp, buf_push;
  logic [CW:0]     used;
  logic [XLEN-1:0] head_pc;
  logic [CW-1:0]   pcq_count, buf_count;
  logic            pcq_full, pcq_empty, buf_full, buf_empty;
  logic [2*XLEN-1:0] buf_head;
  fetch_entry_t    buf_in, buf_out;

  assign req_q  = (state_q == ST_REQ);
  assign grant  = req_q & imem_gnt_i;
  assign resp   = imem_rvalid_i;
  assign used   = (CW+1)'(outstanding_q) + (CW+1)'(req_q) + (CW+1)'(buf_count);
  assign pc_ready_o = ~req_q & (used < (CW+1)'(DEPTH)) & ~flush_i;
  assign accept = pc_valid_i & pc_ready_o;
  assign buf_push = resp & ~flush_i & (discard_q == '0);

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;

  // Flush snapshots outstanding after this cycle's grant/response; otherwise
  // drained responses and late grants of a killed request adjust the count.
  always_comb begin
    outstanding_d = outstanding_q + CW'(grant) - CW'(resp);
    discard_d     = discard_q;
    if (flush_i) begin
      discard_d = outstanding_d;
    end else begin
      if (resp && discard_q != '0) discard_d = discard_d - 1'b1;
      if (grant && kill_pend_q)    discard_d = discard_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      kill_pend_q   <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (grant)                          kill_pend_q <= 1'b0;
      else if (flush_i && req_q)          kill_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: if (accept) begin
          state_q <= ST_REQ;
          addr_q  <= pc_i;
        end
        ST_REQ:  if (grant) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ifu_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_queue (
    .clk     (clk),
    .reset   (reset),
    .clear_i (1'b0),
    .push_i  (grant),
    .data_i  (addr_q),
    .pop_i   (resp),
    .data_o  (head_pc),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_count)
  );

  assign buf_in = '{inst: imem_rdata_i, pc: head_pc};

  ifu_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_inst_buf (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush_i),
    .push_i  (buf_push),
    .data_i  (buf_in),
    .pop_i   (inst_valid_o & inst_ready_i),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign buf_out      = fetch_entry_t'(buf_head);
  assign inst_valid_o = ~buf_empty;
  assign inst_o       = buf_out.inst;
  assign inst_pc_o    = buf_out.pc;

  a_rvalid_needs_outstanding : assert property (
    @(posedge clk) disable iff (reset) imem_rvalid_i |-> (outstanding_q != '0));

  logic unused_ok;
  assign unused_ok = &{1'b0, pcq_full, pcq_empty, pcq_count, buf_full};

endmodule

`default_nettype wire
